// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_pkg
//  Purpose  : Shared constants for the ADC capture controller: FSM state
//             encoding, trigger-mode codes and a small mode helper.
//  Revision : 1.0 - initial release
// ============================================================================
package adc_capture_pkg;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Trigger modes; the reserved code behaves like immediate capture
  localparam logic [1:0] MODE_IMM    = 2'd0;
  localparam logic [1:0] MODE_THRESH = 2'd1;
  localparam logic [1:0] MODE_EXT    = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  // True for modes that wait in ARMED for a trigger event
  function automatic logic mode_needs_trigger(input logic [1:0] mode);
    return (mode == MODE_THRESH) || (mode == MODE_EXT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_trig_detect.sv
`default_nettype none
// ============================================================================
//  Module   : adc_trig_detect
//  Purpose  : Trigger detection for threshold-rising and external trigger
//             modes. Produces a single-cycle fire flag aligned with the
//             triggering in_valid sample.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_trig_detect
  import adc_capture_pkg::*;
#(
  parameter int ADC_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 armed,
  input  logic [1:0]           mode,
  input  logic [ADC_WIDTH-1:0] thresh,
  input  logic [ADC_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 ext_trig,
  output logic                 fire
);

  logic [ADC_WIDTH-1:0] prev_q, prev_d;
  logic                 seeded_q, seeded_d;

  // Evaluate trigger condition; the first valid sample after arming only seeds prev
  always_comb begin
    prev_d   = prev_q;
    seeded_d = seeded_q;
    fire     = 1'b0;
    if (arm) begin
      seeded_d = 1'b0;
    end else if (armed && in_valid) begin
      case (mode)
        MODE_THRESH: begin
          fire     = seeded_q &&
                     ($signed(prev_q) < $signed(thresh)) &&
                     ($signed(in_data) >= $signed(thresh));
          prev_d   = in_data;
          seeded_d = 1'b1;
        end
        MODE_EXT: fire = ext_trig;
        default:  fire = 1'b0;
      endcase
    end
  end

  // Previous-sample and seed flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      seeded_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      seeded_q <= seeded_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_ctrl
//  Purpose  : Captures a configurable-length burst of ADC samples after an
//             immediate, threshold-rising or external trigger and forwards
//             them through a single output register with ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int ADC_WIDTH = 10,
  parameter int LEN_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [1:0]           cfg_mode,
  input  logic [ADC_WIDTH-1:0] cfg_thresh,
  input  logic                 ext_trig,
  input  logic [ADC_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_ovf,
  output logic [ADC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 drop_err,
  output logic [7:0]           ovf_count
);

  localparam logic [LEN_WIDTH:0] CNT_ONE  = {{LEN_WIDTH{1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH:0] FULL_LEN = {1'b1, {LEN_WIDTH{1'b0}}};

  logic [1:0]           state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [1:0]           mode_q, mode_d;
  logic [ADC_WIDTH-1:0] thresh_q, thresh_d;
  logic [LEN_WIDTH:0]   cnt_q, cnt_d;
  logic                 final_q, final_d;
  logic [ADC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 drop_err_q, drop_err_d;
  logic [7:0]           ovf_count_q, ovf_count_d;

  logic                 trig_arm;
  logic                 trig_fire;
  logic                 eligible;
  logic                 accept;
  logic                 drain;
  logic [LEN_WIDTH:0]   target_len;
  logic [LEN_WIDTH:0]   cnt_inc;

  // A zero length encodes the full 2^LEN_WIDTH burst
  assign target_len = (len_q == '0) ? FULL_LEN : {1'b0, len_q};
  assign cnt_inc    = cnt_q + CNT_ONE;
  assign drain      = out_valid_q && out_ready;
  assign trig_arm   = (state_q == ST_IDLE) && start && !abort;

  adc_trig_detect #(
    .ADC_WIDTH (ADC_WIDTH)
  ) u_trig (
    .clk      (clk),
    .rst      (rst),
    .arm      (trig_arm),
    .armed    (state_q == ST_ARMED),
    .mode     (mode_q),
    .thresh   (thresh_q),
    .in_data  (in_data),
    .in_valid (in_valid),
    .ext_trig (ext_trig),
    .fire     (trig_fire)
  );

  // FSM, sample acceptance into the output register, and status bookkeeping
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    mode_d      = mode_q;
    thresh_d    = thresh_q;
    cnt_d       = cnt_q;
    final_d     = final_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    drop_err_d  = drop_err_q;
    ovf_count_d = ovf_count_q;
    eligible    = 1'b0;
    accept      = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_d       = cfg_len;
            mode_d      = cfg_mode;
            thresh_d    = cfg_thresh;
            cnt_d       = '0;
            final_d     = 1'b0;
            drop_err_d  = 1'b0;
            ovf_count_d = 8'd0;
            state_d     = mode_needs_trigger(cfg_mode) ? ST_ARMED : ST_CAPTURE;
          end
        end
        ST_ARMED: begin
          // The triggering sample itself is captured as sample 1
          if (trig_fire) begin
            state_d  = ST_CAPTURE;
            eligible = 1'b1;
          end
        end
        ST_CAPTURE: begin
          eligible = in_valid && !final_q;
          if (drain && out_last_q) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase

      accept = eligible && (!out_valid_q || out_ready);

      if (accept) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
        out_last_d  = (cnt_inc == target_len);
        final_d     = (cnt_inc == target_len);
        cnt_d       = cnt_inc;
        if (in_ovf && (ovf_count_q != 8'hFF)) begin
          ovf_count_d = ovf_count_q + 8'd1;
        end
      end else if (drain) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end

      // Output register full and not emptying: sample is lost
      if (eligible && !accept) begin
        drop_err_d = 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      mode_q      <= MODE_IMM;
      thresh_q    <= '0;
      cnt_q       <= '0;
      final_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      drop_err_q  <= 1'b0;
      ovf_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      thresh_q    <= thresh_d;
      cnt_q       <= cnt_d;
      final_q     <= final_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      drop_err_q  <= drop_err_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign drop_err  = drop_err_q;
  assign ovf_count = ovf_count_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_capture_ctrl
//  Purpose  : Self-checking bench for adc_capture_ctrl. Expected outputs are
//             queued when samples are driven and popped on each handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, ext_trig, in_valid, in_ovf, out_ready;
  logic [11:0] cfg_len;
  logic [1:0]  cfg_mode;
  logic [9:0]  cfg_thresh, in_data, out_data;
  logic        out_valid, out_last, busy, done, drop_err;
  logic [7:0]  ovf_count;

  int errors = 0;
  int checks = 0;

  logic [10:0] sb_q[$];

  // Reference model of the capture sequence
  bit m_active, m_armed, m_final, m_occ, m_drop, m_done_exp;
  int m_cnt, m_len, m_ovf;
  bit prev_stall;
  logic [9:0] held_data;
  logic       held_last;

  always #5 clk = ~clk;

  adc_capture_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_len    (cfg_len),
    .cfg_mode   (cfg_mode),
    .cfg_thresh (cfg_thresh),
    .ext_trig   (ext_trig),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ovf     (in_ovf),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .drop_err   (drop_err),
    .ovf_count  (ovf_count)
  );

  // One clock cycle: drive inputs, check outputs at negedge, advance model
  task automatic cyc(input logic v, input logic [9:0] d, input logic o,
                     input logic r, input logic trig);
    logic [10:0] e;
    bit last, elig, acc;
    in_valid  = v;
    in_data   = d;
    in_ovf    = o;
    out_ready = r;
    @(negedge clk);
    checks++;
    if (done !== m_done_exp) begin
      errors++;
      $display("FAIL done: got %b want %b at %0t", done, m_done_exp, $time);
    end
    checks++;
    if (out_valid !== m_occ) begin
      errors++;
      $display("FAIL out_valid: got %b want %b at %0t", out_valid, m_occ, $time);
    end
    if (prev_stall) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
        errors++;
        $display("FAIL hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", out_valid, out_data,
                 out_last, held_data, held_last);
      end
    end
    if (out_valid === 1'b1 && r) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got d=%h with empty scoreboard", out_data);
      end else begin
        e = sb_q.pop_front();
        if ({out_last, out_data} !== e) begin
          errors++;
          $display("FAIL out_data: got last=%b data=%h want last=%b data=%h",
                   out_last, out_data, e[10], e[9:0]);
        end
      end
    end
    prev_stall = (out_valid === 1'b1) && !r;
    held_data  = out_data;
    held_last  = out_last;

    m_done_exp = 1'b0;
    if (m_armed && v && trig) begin
      m_armed  = 1'b0;
      m_active = 1'b1;
    end
    elig = m_active && !m_final && v;
    acc  = elig && (!m_occ || r);
    if (elig && !acc) m_drop = 1'b1;
    if (acc) begin
      m_cnt++;
      last = (m_cnt == m_len);
      sb_q.push_back({last, d});
      m_occ   = 1'b1;
      m_final = last;
      if (o && m_ovf < 255) m_ovf++;
    end else if (m_occ && r) begin
      m_occ = 1'b0;
      if (m_final) begin
        m_active   = 1'b0;
        m_done_exp = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] mode, input int len, input logic [9:0] thr);
    cfg_mode   = mode;
    cfg_len    = 12'(len);
    cfg_thresh = thr;
    start      = 1'b1;
    cyc(1'b0, 10'h0, 1'b0, 1'b1, 1'b0);
    start      = 1'b0;
    m_cnt   = 0;
    m_len   = (len == 0) ? 4096 : len;
    m_final = 1'b0;
    m_drop  = 1'b0;
    m_ovf   = 0;
    m_armed  = (mode == 2'd1) || (mode == 2'd2);
    m_active = !m_armed;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    // Configuration must be ignored once the capture is running
    cfg_len    = 12'($urandom);
    cfg_mode   = 2'($urandom);
    cfg_thresh = 10'($urandom);
  endtask

  task automatic flush();
    for (int i = 0; i < 40 && (m_active || m_armed || m_done_exp || sb_q.size() != 0); i++)
      cyc(1'b0, 10'h0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (m_active || m_armed || m_done_exp || sb_q.size() != 0) begin
      errors++;
      $display("FAIL flush_timeout: got %0d pending outputs want 0", sb_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done: got %b want 0", busy);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({out_valid, out_last, out_data, busy, done, drop_err, ovf_count} !== '0) begin
      errors++;
      $display("FAIL %s: got v=%b l=%b d=%h busy=%b done=%b drop=%b ovf=%0d want all 0",
               tag, out_valid, out_last, out_data, busy, done, drop_err, ovf_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mode0_ramp();
    do_start(2'd0, 4, 10'h0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 10'(i), 1'b0, 1'b1, 1'b0);
    flush();
    checks++;
    if (drop_err !== 1'b0) begin
      errors++;
      $display("FAIL ramp_drop_err: got %b want 0", drop_err);
    end
  endtask

  task automatic test_thresh_rising();
    do_start(2'd1, 2, 10'h100);
    cyc(1'b1, 10'h0F0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 10'h0FF, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 10'h100, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 10'h101, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 10'h102, 1'b0, 1'b1, 1'b0);
    flush();
  endtask

  task automatic test_thresh_signed();
    do_start(2'd1, 1, 10'h000);
    cyc(1'b1, 10'h3FF, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 10'h001, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 10'h002, 1'b0, 1'b1, 1'b0);
    flush();
  endtask

  task automatic test_ext_trig();
    do_start(2'd2, 2, 10'h0);
    cyc(1'b1, 10'h060, 1'b0, 1'b1, 1'b0);
    ext_trig = 1'b1;
    cyc(1'b0, 10'h0AA, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 10'h061, 1'b0, 1'b1, 1'b1);
    ext_trig = 1'b0;
    cyc(1'b1, 10'h062, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 10'h063, 1'b0, 1'b1, 1'b0);
    flush();
  endtask

  task automatic test_backpressure();
    do_start(2'd0, 8, 10'h0);
    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin
        cfg_len  = 12'd2;
        cfg_mode = 2'd0;
        start    = 1'b1;
      end
      cyc(1'b1, 10'h010 + 10'(i), 1'b0, !(i >= 3 && i <= 5), 1'b0);
      start = 1'b0;
    end
    checks++;
    if (drop_err !== m_drop || m_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_err: got %b want 1", drop_err);
    end
    flush();
  endtask

  task automatic test_abort();
    do_start(2'd0, 8, 10'h0);
    cyc(1'b1, 10'h020, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 10'h021, 1'b0, 1'b1, 1'b0);
    abort = 1'b1;
    start = 1'b1;
    cyc(1'b0, 10'h0, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    start = 1'b0;
    sb_q.delete();
    m_occ = 1'b0; m_active = 1'b0; m_armed = 1'b0; m_final = 1'b0; prev_stall = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: got out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 10'h022 + 10'(i), 1'b0, 1'b1, 1'b0);
    do_start(2'd0, 2, 10'h0);
    cyc(1'b1, 10'h030, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 10'h031, 1'b0, 1'b1, 1'b0);
    flush();
  endtask

  task automatic test_ovf_and_rst();
    do_start(2'd0, 3, 10'h0);
    cyc(1'b1, 10'h040, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 10'h041, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 10'h042, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 10'h043, 1'b1, 1'b1, 1'b0);
    flush();
    checks++;
    if (ovf_count !== 8'(m_ovf) || m_ovf != 2) begin
      errors++;
      $display("FAIL ovf_count: got %0d want 2", ovf_count);
    end
    do_start(2'd0, 8, 10'h0);
    cyc(1'b1, 10'h050, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 10'h051, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check_all_zero("rst_mid_capture");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    m_occ = 1'b0; m_active = 1'b0; m_armed = 1'b0; m_final = 1'b0;
    m_done_exp = 1'b0; prev_stall = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 10'h060, 1'b0, 1'b1, 1'b0);
    check_all_zero("idle_after_rst");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ext_trig = 1'b0;
    in_valid = 1'b0; in_ovf = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_len = '0; cfg_mode = '0; cfg_thresh = '0;
    test_reset();
    test_mode0_ramp();
    test_thresh_rising();
    test_thresh_signed();
    test_ext_trig();
    test_backpressure();
    test_abort();
    test_ovf_and_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
